neopixel_frame_ctrl: RTL and testbench

Frame sequencer for a daisy-chained WS2812 string. It holds a per-pixel colour buffer written by the host logic. On request it streams the buffer, one 24-bit word per pixel, over a valid/ready handshake into the single-pixel neopixel bit serializer. After the last pixel it times the >80 us latch gap itself and pulses frame_done. Sits between the board's control/register logic and the neopixel one_wire driver on the motor board.

---
 rtl/neopixel_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_neopixel_frame_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_frame_ctrl.sv
// Frame sequencer for a WS2812 chain: pixel buffer, per-pixel valid/ready streaming, latch gap timing.
// Optional AUTO_REFRESH_EN adds a free-running refresh generator (parameter REFRESH_HZ).
module neopixel_frame_ctrl #(
  parameter int unsigned NUM_PIXELS     = 8,
  parameter int unsigned CLOCK_SPEED_HZ = 32_000_000,
  parameter int unsigned LATCH_CYCLES   = CLOCK_SPEED_HZ / 12500,
`ifdef AUTO_REFRESH_EN
  parameter int unsigned REFRESH_HZ     = 60,
`endif
  parameter int unsigned AW             = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_color,
  input  logic          refresh,
  output logic          busy,
  output logic          frame_done,
  output logic [23:0]   px_color,
  output logic          px_valid,
  input  logic          px_ready
);

  localparam int unsigned LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LW-1:0] LatchLast = LW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] IdxLast   = AW'(NUM_PIXELS - 1);
  localparam bit AddrFull = (NUM_PIXELS == (2 ** AW));

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StLatch} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [23:0]   px_color_q, px_color_d;
  logic          px_valid_q, px_valid_d;
  logic          refresh_int;
  logic          addr_ok;
  logic [23:0]   load_word;

  // Sized to the address space; rows at or above NUM_PIXELS are never written or read.
  logic [23:0] pix_buf [2**AW];

  generate
    if (AddrFull) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_range
      assign addr_ok = (wr_addr < AW'(NUM_PIXELS));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_en && addr_ok) begin
      pix_buf[wr_addr] <= wr_color;
    end
  end

  // Same-cycle write to the word being loaded wins over the stale buffer contents.
  assign load_word = (wr_en && (wr_addr == idx_q)) ? wr_color : pix_buf[idx_q];

`ifdef AUTO_REFRESH_EN
  localparam int unsigned Period = CLOCK_SPEED_HZ / REFRESH_HZ;
  localparam int unsigned PW = (Period > 1) ? $clog2(Period) : 1;

  logic [PW-1:0] tick_q;
  logic          auto_pulse;

  assign auto_pulse = (tick_q == PW'(Period - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= auto_pulse ? '0 : tick_q + PW'(1);
    end
  end

  assign refresh_int = refresh | auto_pulse;
`else
  assign refresh_int = refresh;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    lcnt_d     = lcnt_q;
    px_color_d = px_color_q;
    px_valid_d = px_valid_q;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (refresh_int || pending_q) begin
          state_d   = StLoad;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      StLoad: begin
        if (refresh_int) pending_d = 1'b1;
        px_color_d = load_word;
        px_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (refresh_int) pending_d = 1'b1;
        if (px_ready) begin
          px_valid_d = 1'b0;
          if (idx_q == IdxLast) begin
            state_d = StLatch;
            lcnt_d  = '0;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = StLoad;
          end
        end
      end
      StLatch: begin
        if (lcnt_q == LatchLast) begin
          frame_done = 1'b1;
          idx_d      = '0;
          lcnt_d     = '0;
          // A queued or coincident request chains the next frame with no idle gap.
          if (pending_q || refresh_int) begin
            state_d   = StLoad;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (refresh_int) pending_d = 1'b1;
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      lcnt_q     <= '0;
      px_color_q <= '0;
      px_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      lcnt_q     <= lcnt_d;
      px_color_q <= px_color_d;
      px_valid_q <= px_valid_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign px_color = px_color_q;
  assign px_valid = px_valid_q;

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Directed self-checking bench for neopixel_frame_ctrl (4 pixels, 16-cycle latch gap).
module tb_neopixel_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_color = '0;
  logic        refresh = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [23:0] px_color;
  logic        px_valid;
  logic        px_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  neopixel_frame_ctrl #(
    .NUM_PIXELS  (4),
    .LATCH_CYCLES(16),
    .AW          (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_color  (wr_color),
    .refresh   (refresh),
    .busy      (busy),
    .frame_done(frame_done),
    .px_color  (px_color),
    .px_valid  (px_valid),
    .px_ready  (px_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered with the DUT sampled in LOAD; leaves it sampled right after the handshake edge.
  // wr_mode: 0 none, 1 write during the LOAD cycle, 2 write during SEND.
  task automatic send_pixel(input logic [23:0] exp, input int stall, input bit ref_pulse,
                            input int wr_mode, input logic [2:0] wa, input logic [23:0] wc);
    if (wr_mode == 1) begin
      wr_en = 1'b1; wr_addr = wa; wr_color = wc;
    end
    tick();
    wr_en = 1'b0;
    check("px_valid_up", {31'd0, px_valid}, 32'd1);
    check("px_color", {8'd0, px_color}, {8'd0, exp});
    if (wr_mode == 2) begin
      wr_en = 1'b1; wr_addr = wa; wr_color = wc;
    end
    if (stall > 0) begin
      px_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        wr_en = 1'b0;
        check("stall_valid", {31'd0, px_valid}, 32'd1);
        check("stall_color", {8'd0, px_color}, {8'd0, exp});
      end
      px_ready = 1'b1;
    end
    if (ref_pulse) refresh = 1'b1;
    tick();
    wr_en   = 1'b0;
    refresh = 1'b0;
    check("gap_valid_low", {31'd0, px_valid}, 32'd0);
  endtask

  // Entered on the first LATCH sample; leaves it sampled on the frame_done cycle.
  task automatic latch_wait(input bit ref_mid);
    int pulses = 0;
    int valids = 0;
    for (int k = 0; k < 16; k++) begin
      if (frame_done) pulses++;
      if (px_valid) valids++;
      if (k == 15) check("done_at_end", {31'd0, frame_done}, 32'd1);
      if (k < 15) begin
        refresh = ref_mid && (k == 5);
        tick();
        refresh = 1'b0;
      end
    end
    check("done_pulses", pulses, 32'd1);
    check("latch_valid_low", valids, 32'd0);
  endtask

  task automatic start_frame();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_valid_low", {31'd0, px_valid}, 32'd0);
  endtask

  logic [23:0] c [4];
  int busy_cnt;

  initial begin
    c[0] = 24'h00FF00; c[1] = 24'hFF0000; c[2] = 24'h0000FF; c[3] = 24'h123456;

    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_valid", {31'd0, px_valid}, 32'd0);
    check("rst_color", {8'd0, px_color}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_color = c[i];
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Plain frame, ready always high
    start_frame();
    for (int i = 0; i < 4; i++) send_pixel(c[i], 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_done_low", {31'd0, frame_done}, 32'd0);

    // Backpressure on pixel 1
    start_frame();
    send_pixel(c[0], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[1], 10, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[2], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[3], 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Refresh during pixel 2 and during latch: exactly one chained frame
    start_frame();
    send_pixel(c[0], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[1], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[2], 0, 1'b1, 0, 3'd0, 24'd0);
    send_pixel(c[3], 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b1);
    tick();
    check("t3_chain_busy", {31'd0, busy}, 32'd1);
    check("t3_chain_valid_low", {31'd0, px_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_pixel(c[i], 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy) busy_cnt++;
      tick();
    end
    check("t3_no_third", busy_cnt, 32'd0);

    // Writes during a frame: unloaded index goes now, loaded index goes next frame
    start_frame();
    send_pixel(c[0], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[1], 0, 1'b0, 2, 3'd3, 24'hABCDEF);
    send_pixel(c[2], 0, 1'b0, 2, 3'd0, 24'h0A0B0C);
    send_pixel(24'hABCDEF, 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();
    wr_en = 1'b1; wr_addr = 3'd7; wr_color = 24'h777777;
    tick();
    wr_en = 1'b0;
    check("t4_oob_busy", {31'd0, busy}, 32'd0);
    check("t4_oob_valid", {31'd0, px_valid}, 32'd0);
    tick();
    start_frame();
    send_pixel(24'h0A0B0C, 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(24'h55AA55, 0, 1'b0, 1, 3'd1, 24'h55AA55);
    send_pixel(c[2], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(24'hABCDEF, 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of pixel 2
    start_frame();
    send_pixel(24'h0A0B0C, 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(24'h55AA55, 0, 1'b0, 0, 3'd0, 24'd0);
    px_ready = 1'b0;
    tick();
    check("t5_pre_valid", {31'd0, px_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, px_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, frame_done}, 32'd0);
    tick();
    reset = 1'b0;
    px_ready = 1'b1;
    tick();
    check("t5_post_idle", {31'd0, busy}, 32'd0);
    start_frame();
    send_pixel(24'h0A0B0C, 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(24'h55AA55, 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(c[2], 0, 1'b0, 0, 3'd0, 24'd0);
    send_pixel(24'hABCDEF, 0, 1'b0, 0, 3'd0, 24'd0);
    latch_wait(1'b0);
    tick();

    // No frames start without a refresh request
    busy_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy) busy_cnt++;
      tick();
    end
    check("t6_no_auto", busy_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
